// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared state encoding and defaults for the I/O cycle master
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } io_state_e;

  localparam int         TDIV_DEFAULT = 4;
  localparam logic [7:0] RDATA_RESET  = 8'hFF;

endpackage

// File: rtl/tstate_timer.sv
// rtl/tstate_timer.sv - T-state prescaler; tick marks the last clk of each T-state
module tstate_timer #(
  parameter int TDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] LAST = 4'(TDIV - 1);

  logic [3:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Held at zero while idle so every cycle starts T1 on a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = 4'd0;
    end else if (tick) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_cycle_master.sv
// rtl/io_cycle_master.sv - Z80-style I/O bus cycle master (T1, T2, TW, T3 per access)
module io_cycle_master
  import io_bus_pkg::*;
#(
  parameter int TDIV = TDIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] port_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       resp,
  output logic [7:0] a,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  input  logic       busdir
);

  io_state_e  state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       resp_q, resp_d;
  logic       done_q, done_d;
  logic       tick;
  logic       strobe;

  tstate_timer #(.TDIV(TDIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = T1;
          wr_d    = wr;
          addr_d  = port_addr;
          wdata_d = wdata;
        end
      end
      T1: if (tick) state_d = T2;
      T2: if (tick) state_d = TW;
      TW: if (tick) state_d = T3;
      T3: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          resp_d  = ~busdir;
          if (!wr_q) rdata_d = d_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= RDATA_RESET;
      resp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset releases them at once.
  assign busy   = (state_q != IDLE);
  assign strobe = (state_q == T2) || (state_q == TW) || (state_q == T3);
  assign iorq_n = ~strobe;
  assign rd_n   = ~(strobe & ~wr_q);
  assign wr_n   = ~(strobe & wr_q);
  assign d_oe   = busy & wr_q;
  assign d_out  = wdata_q;
  assign a      = addr_q;
  assign rdata  = rdata_q;
  assign resp   = resp_q;
  assign done   = done_q;

endmodule

// File: tb/tb_io_cycle_master.sv
// tb/tb_io_cycle_master.sv - self-checking bench for io_cycle_master at TDIV=4 and TDIV=1
module tb_io_cycle_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[2], start_v[2], wr_v[2], busdir_v[2];
  logic [7:0] addr_v[2], wdata_v[2], din_v[2];
  logic       busy_o[2], done_o[2], iorq_o[2], rd_o[2], wr_o[2], doe_o[2], resp_o[2];
  logic [7:0] rdata_o[2], a_o[2], dout_o[2];

  io_cycle_master #(.TDIV(4)) u_t4 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .wr(wr_v[0]),
    .port_addr(addr_v[0]), .wdata(wdata_v[0]), .busy(busy_o[0]), .done(done_o[0]),
    .rdata(rdata_o[0]), .resp(resp_o[0]), .a(a_o[0]), .iorq_n(iorq_o[0]),
    .rd_n(rd_o[0]), .wr_n(wr_o[0]), .d_out(dout_o[0]), .d_oe(doe_o[0]),
    .d_in(din_v[0]), .busdir(busdir_v[0])
  );

  io_cycle_master #(.TDIV(1)) u_t1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .wr(wr_v[1]),
    .port_addr(addr_v[1]), .wdata(wdata_v[1]), .busy(busy_o[1]), .done(done_o[1]),
    .rdata(rdata_o[1]), .resp(resp_o[1]), .a(a_o[1]), .iorq_n(iorq_o[1]),
    .rd_n(rd_o[1]), .wr_n(wr_o[1]), .d_out(dout_o[1]), .d_oe(doe_o[1]),
    .d_in(din_v[1]), .busdir(busdir_v[1])
  );

  int vectors = 0;
  int errors  = 0;

  // Model: position in the access counted in clks since the accept edge (0 = idle).
  int         m_pos[2]   = '{0, 0};
  logic       m_wr[2]    = '{1'b0, 1'b0};
  logic       m_done[2]  = '{1'b0, 1'b0};
  logic       m_resp[2]  = '{1'b0, 1'b0};
  logic [7:0] m_addr[2]  = '{8'h00, 8'h00};
  logic [7:0] m_wdata[2] = '{8'h00, 8'h00};
  logic [7:0] m_rdata[2] = '{8'hFF, 8'hFF};

  function automatic int tdiv_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        m_pos[i] = 0; m_done[i] = 1'b0; m_wr[i] = 1'b0; m_resp[i] = 1'b0;
        m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_rdata[i] = 8'hFF;
      end else begin
        m_done[i] = 1'b0;
        if (m_pos[i] == 0) begin
          if (start_v[i]) begin
            m_wr[i] = wr_v[i]; m_addr[i] = addr_v[i]; m_wdata[i] = wdata_v[i];
            m_pos[i] = 1;
          end
        end else if (m_pos[i] == 4 * tdiv_of(i)) begin
          if (!m_wr[i]) m_rdata[i] = din_v[i];
          m_resp[i] = ~busdir_v[i];
          m_done[i] = 1'b1;
          m_pos[i]  = 0;
        end else begin
          m_pos[i]++;
        end
      end
    end
  end

  function automatic logic [30:0] expect_vec(int i);
    logic act, on;
    if (rst_v[i]) return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0};
    on  = (m_pos[i] != 0);
    act = (m_pos[i] > tdiv_of(i));
    return {on, m_done[i], ~act, ~(act & ~m_wr[i]), ~(act & m_wr[i]), on & m_wr[i],
            (on & m_wr[i]) ? m_wdata[i] : 8'h00, m_addr[i], m_rdata[i], m_resp[i]};
  endfunction

  function automatic logic [30:0] actual_vec(int i);
    return {busy_o[i], done_o[i], iorq_o[i], rd_o[i], wr_o[i], doe_o[i],
            (doe_o[i] | rst_v[i]) ? dout_o[i] : 8'h00, a_o[i], rdata_o[i], resp_o[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (actual_vec(i) !== expect_vec(i)) begin
        errors++;
        $display("FAIL cycle_t%0d at %0t: dut=%h model=%h", tdiv_of(i), $time,
                 actual_vec(i), expect_vec(i));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input int i, input logic w, input logic [7:0] ad,
                           input logic [7:0] wd, output int done_clk,
                           output int n_rd, output int n_wr, output int n_oe);
    start_v[i] = 1'b1; wr_v[i] = w; addr_v[i] = ad; wdata_v[i] = wd;
    step();
    start_v[i] = 1'b0;
    done_clk = -1; n_rd = 0; n_wr = 0; n_oe = 0;
    for (int n = 1; n < 100; n++) begin
      if (!rd_o[i]) n_rd++;
      if (!wr_o[i]) n_wr++;
      if (doe_o[i] && dout_o[i] == wd) n_oe++;
      if (done_o[i]) begin
        done_clk = n;
        break;
      end
      step();
    end
  endtask

  int dclk, nrd, nwr, noe, first_done, second_done, idle_ok;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; wr_v[i] = 1'b0; busdir_v[i] = 1'b1;
      addr_v[i] = 8'h00; wdata_v[i] = 8'h00; din_v[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vec_t4", {1'b0, actual_vec(0)}, 32'h1C0001FE);
    chk("reset_vec_t1", {1'b0, actual_vec(1)}, 32'h1C0001FE);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    // Single IN, responder drives 5A
    din_v[0] = 8'h5A; busdir_v[0] = 1'b0;
    run_cycle(0, 1'b0, 8'h00, 8'h00, dclk, nrd, nwr, noe);
    chk("in_done_clk", dclk, 17);
    chk("in_rdata", rdata_o[0], 8'h5A);
    chk("in_model_rdata", m_rdata[0], 8'h5A);
    chk("in_resp", resp_o[0], 1);
    chk("in_rd_low_clks", nrd, 12);
    chk("in_wr_low_clks", nwr, 0);
    step();

    // Single OUT of C3 to port 01
    run_cycle(0, 1'b1, 8'h01, 8'hC3, dclk, nrd, nwr, noe);
    chk("out_done_clk", dclk, 17);
    chk("out_wr_low_clks", nwr, 12);
    chk("out_dout_oe_clks", noe, 16);
    chk("out_rd_low_clks", nrd, 0);
    chk("out_rdata_kept", rdata_o[0], 8'h5A);
    chk("out_addr", a_o[0], 8'h01);
    step();

    // No responder
    busdir_v[0] = 1'b1; din_v[0] = 8'hFF;
    run_cycle(0, 1'b0, 8'h7F, 8'h00, dclk, nrd, nwr, noe);
    chk("noresp_done_clk", dclk, 17);
    chk("noresp_rdata", rdata_o[0], 8'hFF);
    chk("noresp_resp", resp_o[0], 0);
    chk("noresp_addr", a_o[0], 8'h7F);
    step();

    // Back-to-back with start held high
    busdir_v[0] = 1'b0; din_v[0] = 8'h33;
    start_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 8'h10;
    first_done = -1; second_done = -1;
    for (int n = 0; n < 60; n++) begin
      if (done_o[0]) begin
        if (first_done < 0) first_done = n;
        else second_done = n;
      end
      step();
      if (second_done >= 0) break;
    end
    start_v[0] = 1'b0;
    chk("b2b_first_done", first_done, 17);
    chk("b2b_spacing", second_done - first_done, 17);
    idle_ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy_o[0] && !done_o[0]) begin
        idle_ok = 1;
        break;
      end
      step();
    end
    chk("b2b_returns_idle", idle_ok, 1);
    step();

    // Reset during TW (clks 9..12 at TDIV=4)
    start_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 8'h22;
    step();
    start_v[0] = 1'b0;
    repeat (9) step();
    chk("pre_rst_rd_low", rd_o[0], 0);
    rst_v[0] = 1'b1;
    #1;
    chk("rst_iorq_high", iorq_o[0], 1);
    chk("rst_rd_high", rd_o[0], 1);
    chk("rst_busy_low", busy_o[0], 0);
    step();
    rst_v[0] = 1'b0;
    din_v[0] = 8'h96;
    run_cycle(0, 1'b0, 8'h44, 8'h00, dclk, nrd, nwr, noe);
    chk("post_rst_done_clk", dclk, 17);
    chk("post_rst_rdata", rdata_o[0], 8'h96);
    step();

    // TDIV=1 IN
    din_v[1] = 8'hA5; busdir_v[1] = 1'b0;
    run_cycle(1, 1'b0, 8'h05, 8'h00, dclk, nrd, nwr, noe);
    chk("t1_done_clk", dclk, 5);
    chk("t1_rd_low_clks", nrd, 3);
    chk("t1_rdata", rdata_o[1], 8'hA5);
    chk("t1_resp", resp_o[1], 1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/io_cycle_master.md
IO_CYCLE_MASTER -- requirements
Module: io_cycle_master

Interface
REQ-001 SHALL have parameter TDIV, default 4, clk cycles per T-state, legal 1..16.
REQ-002 SHALL have port clk, in, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst, in, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, in, 1, request one I/O cycle.
REQ-005 SHALL have port wr, in, 1, 1=OUT cycle, 0=IN cycle, sampled with start.
REQ-006 SHALL have port port_addr, in, 8, I/O port number, sampled with start.
REQ-007 SHALL have port wdata, in, 8, OUT data, sampled with start.
REQ-008 SHALL have port busy, out, 1, cycle in progress.
REQ-009 SHALL have port done, out, 1, one-clk pulse at cycle end.
REQ-010 SHALL have port rdata, out, 8, last IN data.
REQ-011 SHALL have port resp, out, 1, responder claimed bus (busdir seen low).
REQ-012 SHALL have port a, out, 8, bus address.
REQ-013 SHALL have ports iorq_n, rd_n and wr_n, out, 1 each, active-low strobes.
REQ-014 SHALL have ports d_out, out, 8 and d_oe, out, 1, bus data drive.
REQ-015 SHALL have ports d_in, in, 8 and busdir, in, 1, bus data and responder direction (low = responder driving).

Function
REQ-016 SHALL use FSM states IDLE, T1, T2, TW, T3, each non-IDLE state lasting exactly TDIV clks.
REQ-017 SHALL accept start only in IDLE; in busy states start is ignored, not queued.
REQ-018 SHALL, on accept, latch wr/port_addr/wdata, enter T1 next clk, and raise busy the same clk.
REQ-019 SHALL drive a = latched port_addr from T1 through T3 and hold a after T3 until the next accept.
REQ-020 SHALL assert iorq_n low and either rd_n (IN) or wr_n (OUT) low throughout T2, TW and T3, and keep them high in T1 and IDLE.
REQ-021 SHALL drive d_oe high and d_out = wdata from T1 through T3 for OUT, and keep d_oe low for IN.
REQ-022 SHALL, for IN, capture d_in into rdata on the last clk of T3, leaving rdata unchanged on OUT.
REQ-023 SHALL capture resp = ~busdir on the last clk of T3 for both directions.
REQ-024 SHALL pulse done for one clk in the first IDLE clk after T3, dropping busy that same clk.
REQ-025 SHALL keep total latency from the accept edge to the done pulse at 4*TDIV+1 clks.
REQ-026 SHALL accept a start asserted during the done clk, enabling back-to-back cycles with one IDLE clk between them.
REQ-027 SHALL wrap the T-state counter from TDIV-1 to 0 on each state advance, with a counter width of 4 bits.

Reset
REQ-028 SHALL, on rst high, immediately force IDLE, busy=0, done=0, iorq_n=rd_n=wr_n=1, d_oe=0, a=8'h00, d_out=8'h00, rdata=8'hFF and resp=0.
REQ-029 SHALL, if rst asserts mid-cycle, deassert strobes asynchronously, discard the cycle and not pulse done.
REQ-030 SHALL permit acceptance of start on the first clk after rst deasserts.

Structure
REQ-031 SHALL place the state encoding and the TDIV default in a shared package io_bus_pkg.
REQ-032 SHALL use one sub-module tstate_timer (prescaler producing a last-clk-of-T-state tick).
REQ-033 SHALL drive no tristates internally; pad-level tristate on d is done at top level from d_oe.

Verification
REQ-034 SHALL cover a single IN: TDIV=4, start with wr=0, port_addr=8'h00, responder driving 8'h5A with busdir=0 -> done at clk 17, rdata=8'h5A, resp=1.
REQ-035 SHALL cover a single OUT: port_addr=8'h01, wdata=8'hC3 -> wr_n low for 12 clks, d_out=8'hC3 with d_oe=1 for 16 clks, rd_n stays 1, rdata unchanged.
REQ-036 SHALL cover no responder: IN to port 8'h7F with busdir=1 and d_in=8'hFF -> rdata=8'hFF, resp=0.
REQ-037 SHALL cover back-to-back: start held high -> consecutive done pulses 17 clks apart, start asserted while busy ignored.
REQ-038 SHALL cover reset mid-cycle: rst asserted in TW -> iorq_n/rd_n high the same clk, no done, next start completes normally.
REQ-039 SHALL cover TDIV=1: IN cycle -> done at clk 5, strobes low for exactly 3 clks.
